// File: rtl/sel_decoder_pkg.sv
// rtl/sel_decoder_pkg.sv - shared types and default widths for sel_decoder_seq
package sel_decoder_pkg;

  localparam int SEL_W_DEF   = 3;
  localparam int DWELL_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_e;

  // Where the next y value comes from.
  typedef enum logic [1:0] {
    Y_ZERO = 2'd0,
    Y_HOLD = 2'd1,
    Y_LOAD = 2'd2
  } ysrc_e;

endpackage

// File: rtl/sel_decoder_seq_if.sv
// rtl/sel_decoder_seq_if.sv - select/scan bus between a controller and sel_decoder_seq
interface sel_decoder_seq_if #(
  parameter int SEL_W   = sel_decoder_pkg::SEL_W_DEF,
  parameter int DWELL_W = sel_decoder_pkg::DWELL_W_DEF
);
  localparam int OUT_N = 1 << SEL_W;

  logic               en;
  logic               mode;
  logic               in_valid;
  logic [SEL_W-1:0]   in_sel;
  logic               in_ready;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_N-1:0]   y;
  logic               out_valid;
  logic               scan_wrap;

  modport master (
    output en, mode, in_valid, in_sel, dwell,
    input  in_ready, y, out_valid, scan_wrap
  );

  modport slave (
    input  en, mode, in_valid, in_sel, dwell,
    output in_ready, y, out_valid, scan_wrap
  );
endinterface

// File: rtl/sel_decoder_seq_onehot.sv
// rtl/sel_decoder_seq_onehot.sv - combinational binary to one-hot decoder
module onehot_decode #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]        sel_i,
  output logic [(1<<SEL_W)-1:0]   onehot_o
);
  always_comb begin
    onehot_o        = '0;
    onehot_o[sel_i] = 1'b1;
  end
endmodule

// File: rtl/sel_decoder_seq.sv
// rtl/sel_decoder_seq.sv - one-hot select decoder with an auto-scan mode
module sel_decoder_seq
  import sel_decoder_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  sel_decoder_seq_if.slave bus
);
  localparam int OUT_N = 1 << SEL_W;

  state_e             state_q, state_d;
  logic [OUT_N-1:0]   y_q, y_d;
  logic               out_valid_q, out_valid_d;
  logic               scan_wrap_q, scan_wrap_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  ysrc_e              ysrc;
  logic               xfer;
  logic [SEL_W-1:0]   dec_sel;
  logic [OUT_N-1:0]   dec_out;

  assign bus.in_ready = bus.en & ~bus.mode;
  assign xfer         = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    scan_wrap_d = 1'b0;
    ysrc        = Y_HOLD;
    if (!bus.en) begin
      state_d     = IDLE;
      idx_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
      ysrc        = Y_ZERO;
    end else if (bus.mode) begin
      state_d     = SCAN;
      out_valid_d = 1'b1;
      ysrc        = Y_LOAD;
      if (state_q != SCAN) begin
        idx_d = '0;
        cnt_d = bus.dwell;
      end else if (cnt_q == '0) begin
        // Index width equals log2(OUT_N), so the increment wraps on its own.
        idx_d       = idx_q + SEL_W'(1);
        cnt_d       = bus.dwell;
        scan_wrap_d = &idx_q;
      end else begin
        cnt_d = cnt_q - DWELL_W'(1);
      end
    end else begin
      idx_d = '0;
      cnt_d = '0;
      if (xfer) begin
        state_d     = DECODE;
        out_valid_d = 1'b1;
        ysrc        = Y_LOAD;
      end else if (state_q != DECODE) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        ysrc        = Y_ZERO;
      end
    end
  end

  // Single decoder serves both the decode input and the scan index.
  assign dec_sel = xfer ? bus.in_sel : idx_d;

  onehot_decode #(.SEL_W(SEL_W)) u_dec (
    .sel_i    (dec_sel),
    .onehot_o (dec_out)
  );

  always_comb begin
    y_d = y_q;
    case (ysrc)
      Y_ZERO:  y_d = '0;
      Y_LOAD:  y_d = dec_out;
      default: y_d = y_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      scan_wrap_q <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      scan_wrap_q <= scan_wrap_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = out_valid_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_sel_decoder_seq.sv
// tb/tb_sel_decoder_seq.sv - directed self-checking bench for sel_decoder_seq
module tb_sel_decoder_seq;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  sel_decoder_seq_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();

  sel_decoder_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!$onehot0(bus.y)) begin
      fails++;
      $display("FAIL onehot0: y=%b has more than one bit set", bus.y);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.en = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_sel = '0; bus.dwell = '0;
    step(); step();
    tests++;
    if (bus.y !== 8'h00 || bus.out_valid !== 1'b0 || bus.scan_wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: y=%h ov=%b wrap=%b expected 00/0/0", bus.y, bus.out_valid, bus.scan_wrap);
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    rst_n = 1'b1;
    step();
    tests++;
    if (bus.y !== 8'h00 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: y=%h ov=%b expected 00/0", bus.y, bus.out_valid);
    end
  endtask

  task automatic test_decode();
    bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_sel = 3'd5;
    step();
    tests++;
    if (bus.y !== 8'h20 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL decode_sel5: y=%h ov=%b expected 20/1", bus.y, bus.out_valid);
    end
    bus.in_valid = 1'b0; bus.in_sel = 3'd2;
    step(); step();
    tests++;
    if (bus.y !== 8'h20 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL decode_hold: y=%h ov=%b expected 20/1", bus.y, bus.out_valid);
    end
    bus.mode = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL in_ready_scan_mode: got %b expected 0", bus.in_ready);
    end
    bus.mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] sels [3];
    logic [7:0] exps [3];
    sels = '{3'd0, 3'd7, 3'd3};
    exps = '{8'h01, 8'h80, 8'h08};
    bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_sel = sels[i];
      step();
      tests++;
      if (bus.y !== exps[i] || bus.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL b2b_%0d: y=%h ov=%b expected %h/1", i, bus.y, bus.out_valid, exps[i]);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_scan_dwell2();
    go_idle();
    bus.en = 1'b1; bus.mode = 1'b1; bus.dwell = 4'd2;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 3; k++) begin
        step();
        tests++;
        if (bus.y !== (8'h01 << i) || bus.scan_wrap !== 1'b0 || bus.out_valid !== 1'b1) begin
          fails++;
          $display("FAIL scan_d2_idx%0d_c%0d: y=%h wrap=%b ov=%b expected %h/0/1",
                   i, k, bus.y, bus.scan_wrap, bus.out_valid, 8'h01 << i);
        end
      end
    end
    step();
    tests++;
    if (bus.y !== 8'h01 || bus.scan_wrap !== 1'b1) begin
      fails++;
      $display("FAIL scan_d2_wrap: y=%h wrap=%b expected 01/1", bus.y, bus.scan_wrap);
    end
    step();
    tests++;
    if (bus.y !== 8'h01 || bus.scan_wrap !== 1'b0) begin
      fails++;
      $display("FAIL scan_d2_wrap_pulse: y=%h wrap=%b expected 01/0", bus.y, bus.scan_wrap);
    end
  endtask

  task automatic test_scan_dwell0();
    go_idle();
    bus.en = 1'b1; bus.mode = 1'b1; bus.dwell = 4'd0;
    step();
    tests++;
    if (bus.y !== 8'h01 || bus.scan_wrap !== 1'b0) begin
      fails++;
      $display("FAIL scan_d0_entry: y=%h wrap=%b expected 01/0", bus.y, bus.scan_wrap);
    end
    for (int c = 1; c <= 16; c++) begin
      step();
      tests++;
      if (bus.y !== (8'h01 << (c % 8)) || bus.scan_wrap !== ((c % 8) == 0)) begin
        fails++;
        $display("FAIL scan_d0_c%0d: y=%h wrap=%b expected %h/%b",
                 c, bus.y, bus.scan_wrap, 8'h01 << (c % 8), (c % 8) == 0);
      end
    end
  endtask

  task automatic test_en_drop();
    go_idle();
    bus.en = 1'b1; bus.mode = 1'b1; bus.dwell = 4'd0;
    for (int i = 0; i < 5; i++) step();
    tests++;
    if (bus.y !== 8'h10) begin
      fails++;
      $display("FAIL en_drop_at_idx4: y=%h expected 10", bus.y);
    end
    bus.en = 1'b0;
    step();
    tests++;
    if (bus.y !== 8'h00 || bus.out_valid !== 1'b0 || bus.scan_wrap !== 1'b0) begin
      fails++;
      $display("FAIL en_drop: y=%h ov=%b wrap=%b expected 00/0/0", bus.y, bus.out_valid, bus.scan_wrap);
    end
    bus.en = 1'b1;
    step();
    tests++;
    if (bus.y !== 8'h01 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL en_restart: y=%h ov=%b expected 01/1", bus.y, bus.out_valid);
    end
  endtask

  task automatic test_mode_exit();
    bus.en = 1'b1; bus.mode = 1'b1; bus.dwell = 4'd0;
    step(); step();
    bus.mode = 1'b0; bus.in_valid = 1'b0;
    step();
    tests++;
    if (bus.y !== 8'h00 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mode_exit_idle: y=%h ov=%b expected 00/0", bus.y, bus.out_valid);
    end
    bus.mode = 1'b1;
    step(); step(); step();
    bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_sel = 3'd6;
    step();
    tests++;
    if (bus.y !== 8'h40 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL mode_exit_xfer: y=%h ov=%b expected 40/1", bus.y, bus.out_valid);
    end
    bus.in_valid = 1'b0;
    bus.mode = 1'b1;
    step();
    tests++;
    if (bus.y !== 8'h01 || bus.scan_wrap !== 1'b0) begin
      fails++;
      $display("FAIL scan_reentry: y=%h wrap=%b expected 01/0", bus.y, bus.scan_wrap);
    end
    bus.mode = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.en = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1; bus.in_sel = 3'd4;
    step();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.y !== 8'h10) begin
      fails++;
      $display("FAIL pre_async_decode: y=%h expected 10", bus.y);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.y !== 8'h00 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: y=%h ov=%b expected 00/0", bus.y, bus.out_valid);
    end
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (bus.y !== 8'h00 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_async_reset: y=%h ov=%b expected 00/0", bus.y, bus.out_valid);
    end
    bus.in_valid = 1'b1; bus.in_sel = 3'd1;
    step();
    bus.in_valid = 1'b0;
    tests++;
    if (bus.y !== 8'h02 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL resume_decode: y=%h ov=%b expected 02/1", bus.y, bus.out_valid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus.en = 1'b0; bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_sel = '0; bus.dwell = '0;
    rst_n = 1'b0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_scan_dwell2();
    test_scan_dwell0();
    test_en_drop();
    test_mode_exit();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
